// File: rtl/move_sequencer_if.sv
// rtl/move_sequencer_if.sv - signal bundle between move_sequencer and its neighbours
//
// Purpose: groups the instruction, data-memory, IO-bus and status signals of
// move_sequencer so they can be passed as one port.
// Signals:
//   instruction : instr_valid, op_code[5:0], src_addr[15:0], dst_addr[15:0], len[LEN_W-1:0]
//   memory      : mem_addr[13:0] (word address), mem_rd, mem_wr, mem_wdata[31:0], mem_rdata[31:0]
//   IO bus      : io_req, io_we, io_addr[15:0], io_wdata[31:0], io_rdata[31:0], io_ack
//   status      : pc_hold, busy, done, err, xfer_count[31:0]
// Modports: master = sequencer side, slave = surrounding system side.
interface move_sequencer_if #(
   parameter int LEN_W = 8
);
   logic             instr_valid;
   logic [5:0]       op_code;
   logic [15:0]      src_addr;
   logic [15:0]      dst_addr;
   logic [LEN_W-1:0] len;

   logic [13:0]      mem_addr;
   logic             mem_rd;
   logic             mem_wr;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;

   logic             io_req;
   logic             io_we;
   logic [15:0]      io_addr;
   logic [31:0]      io_wdata;
   logic [31:0]      io_rdata;
   logic             io_ack;

   logic             pc_hold;
   logic             busy;
   logic             done;
   logic             err;
   logic [31:0]      xfer_count;

   modport master (
      input  instr_valid, op_code, src_addr, dst_addr, len,
      input  mem_rdata, io_rdata, io_ack,
      output mem_addr, mem_rd, mem_wr, mem_wdata,
      output io_req, io_we, io_addr, io_wdata,
      output pc_hold, busy, done, err, xfer_count
   );

   modport slave (
      output instr_valid, op_code, src_addr, dst_addr, len,
      output mem_rdata, io_rdata, io_ack,
      input  mem_addr, mem_rd, mem_wr, mem_wdata,
      input  io_req, io_we, io_addr, io_wdata,
      input  pc_hold, busy, done, err, xfer_count
   );
endinterface

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - multi-cycle MOVE executor between data memory and IO space
//
// Purpose: runs op 56 (stall), 57 (single-word move) and 58 (block move),
// holding the PC for the whole instruction. Addresses <= MEM_TOP go to data
// memory, higher addresses go to the IO bus.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - move_sequencer_if.master: instruction in, memory bus, IO bus, status
// Optional feature: define MOVE_XFER_COUNT_EN to get a cumulative word counter
// on xfer_count; otherwise xfer_count is constant 0.
module move_sequencer #(
   parameter int MEM_TOP    = 32764,
   parameter int IO_TIMEOUT = 64,
   parameter int LEN_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   move_sequencer_if.master bus
);
   localparam logic [15:0]      MEM_TOP_A = 16'(MEM_TOP);
   localparam int               TMO_W     = $clog2(IO_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(IO_TIMEOUT - 1);
   localparam logic [5:0]       OP_STALL  = 6'd56;
   localparam logic [5:0]       OP_WORD   = 6'd57;
   localparam logic [5:0]       OP_BLOCK  = 6'd58;

   typedef enum logic [3:0] {
      IDLE, STALL, SRC_MEM, SRC_CAP, SRC_IO, DST_MEM, DST_IO, NEXT, DONE
   } state_t;

   state_t           state, next_state;
   logic [15:0]      src_q, dst_q;
   logic [LEN_W-1:0] rem_q;
   logic [31:0]      data_q;
   logic [TMO_W-1:0] tmo_q;
   logic             err_q, block_q, gap_q;
   logic             accept, op_ok, io_live, io_done, tmo_hit;
   logic [15:0]      src_nx, dst_nx;

   logic [13:0]      mem_addr_c;
   logic             mem_rd_c, mem_wr_c, io_req_c, io_we_c, done_c;
   logic [31:0]      mem_wdata_c, io_wdata_c;
   logic [15:0]      io_addr_c;

   function automatic state_t src_leg(input logic [15:0] a);
      return (a <= MEM_TOP_A) ? SRC_MEM : SRC_IO;
   endfunction

   function automatic state_t dst_leg(input logic [15:0] a);
      return (a <= MEM_TOP_A) ? DST_MEM : DST_IO;
   endfunction

   assign op_ok  = (bus.op_code == OP_STALL) || (bus.op_code == OP_WORD) ||
                   (bus.op_code == OP_BLOCK);
   assign src_nx = src_q + 16'd4;
   assign dst_nx = dst_q + 16'd4;

   // An IO->IO word would otherwise keep io_req high straight from the read
   // into the write; gap_q forces one idle request cycle between the two.
   assign io_live = (state == SRC_IO) || ((state == DST_IO) && !gap_q);
   assign io_done = io_live && bus.io_ack;
   assign tmo_hit = io_live && !bus.io_ack && (tmo_q == TMO_LAST);

   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      mem_addr_c  = '0;
      mem_rd_c    = 1'b0;
      mem_wr_c    = 1'b0;
      mem_wdata_c = '0;
      io_req_c    = 1'b0;
      io_we_c     = 1'b0;
      io_addr_c   = '0;
      io_wdata_c  = '0;
      done_c      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.instr_valid && op_ok && !rst) begin
               accept = 1'b1;
               if (bus.op_code == OP_STALL)
                  next_state = STALL;
               else if ((bus.op_code == OP_BLOCK) && (bus.len == '0))
                  next_state = NEXT;
               else
                  next_state = src_leg(bus.src_addr);
            end
         end
         STALL:   next_state = DONE;
         SRC_MEM: begin
            mem_rd_c   = 1'b1;
            mem_addr_c = src_q[15:2];
            next_state = SRC_CAP;
         end
         SRC_CAP: next_state = dst_leg(dst_q);
         SRC_IO: begin
            io_req_c  = 1'b1;
            io_addr_c = src_q;
            if (io_done)      next_state = dst_leg(dst_q);
            else if (tmo_hit) next_state = DONE;
         end
         DST_MEM: begin
            mem_wr_c    = 1'b1;
            mem_addr_c  = dst_q[15:2];
            mem_wdata_c = data_q;
            next_state  = block_q ? NEXT : DONE;
         end
         DST_IO: begin
            io_req_c   = !gap_q;
            io_we_c    = 1'b1;
            io_addr_c  = dst_q;
            io_wdata_c = data_q;
            if (io_done)      next_state = block_q ? NEXT : DONE;
            else if (tmo_hit) next_state = DONE;
         end
         // rem_q of 0 only happens for len == 0; treat it like the last word.
         NEXT:    next_state = (rem_q <= LEN_W'(1)) ? DONE : src_leg(src_nx);
         DONE: begin
            done_c     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         block_q <= 1'b0;
         gap_q   <= 1'b0;
      end else begin
         state <= next_state;
         gap_q <= (state == SRC_IO) && io_done;
         if (accept) begin
            src_q   <= bus.src_addr;
            dst_q   <= bus.dst_addr;
            rem_q   <= bus.len;
            block_q <= (bus.op_code == OP_BLOCK);
            err_q   <= 1'b0;
         end
         if (state == SRC_CAP)
            data_q <= bus.mem_rdata;
         else if ((state == SRC_IO) && io_done)
            data_q <= bus.io_rdata;
         if (state == NEXT) begin
            src_q <= src_nx;
            dst_q <= dst_nx;
            if (rem_q != '0) rem_q <= rem_q - LEN_W'(1);
         end
         if (io_live && !bus.io_ack && !tmo_hit)
            tmo_q <= tmo_q + TMO_W'(1);
         else
            tmo_q <= '0;
         if (tmo_hit)
            err_q <= 1'b1;
      end
   end

   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_rd    = mem_rd_c;
   assign bus.mem_wr    = mem_wr_c;
   assign bus.mem_wdata = mem_wdata_c;
   assign bus.io_req    = io_req_c;
   assign bus.io_we     = io_we_c;
   assign bus.io_addr   = io_addr_c;
   assign bus.io_wdata  = io_wdata_c;
   assign bus.done      = done_c;
   assign bus.busy      = (state != IDLE);
   assign bus.pc_hold   = accept || (state != IDLE);
   assign bus.err       = err_q;

`ifdef MOVE_XFER_COUNT_EN
   logic [31:0] xfer_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         xfer_q <= '0;
      else if ((state == DST_MEM) || ((state == DST_IO) && io_done))
         xfer_q <= xfer_q + 32'd1;
   end
   assign bus.xfer_count = xfer_q;
`else
   assign bus.xfer_count = 32'd0;
`endif
endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - self-checking bench for move_sequencer
`timescale 1ns/1ps
module tb_move_sequencer;
   localparam int MEM_TOP    = 32764;
   localparam int IO_TIMEOUT = 64;
   typedef logic [48:0] ent_t;   // {is_io, byte address, data}

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   move_sequencer_if #(.LEN_W(8)) bus ();
   move_sequencer #(.MEM_TOP(MEM_TOP), .IO_TIMEOUT(IO_TIMEOUT), .LEN_W(8))
      dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   logic [31:0] mem     [0:8191];
   logic [31:0] ref_mem [0:8191];

   int   hold_cnt, done_cnt, req_cnt, excl_err, stab_err, io_cnt, io_lat;
   bit   io_never;
   ent_t wlog[$];
   ent_t rlog[$];
   logic [15:0] io_addr_q;
   logic        io_we_q;
   logic [31:0] io_wd_q;

   int   exp_hold, exp_xfer;
   bit   exp_err;
   ent_t exp_w[$];
   ent_t exp_r[$];

   function automatic logic [31:0] io_val(input logic [15:0] a);
      return (a == 16'h8000) ? 32'h1234_5678 : {a ^ 16'h5A3C, a};
   endfunction

   // data memory with one-cycle read latency
   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[12:0]];
      if (bus.mem_wr) mem[bus.mem_addr[12:0]] <= bus.mem_wdata;
   end

   // monitor and IO responder, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.pc_hold) hold_cnt++;
      if (bus.done) done_cnt++;
      if (bus.io_req) req_cnt++;
      if ((bus.mem_rd && bus.mem_wr) || (bus.io_req && (bus.mem_rd || bus.mem_wr))) excl_err++;
      if (bus.mem_rd) rlog.push_back({1'b0, bus.mem_addr, 2'b00, 32'h0});
      if (bus.mem_wr) wlog.push_back({1'b0, bus.mem_addr, 2'b00, bus.mem_wdata});
      if (bus.io_req) begin
         if (io_cnt > 0 && (bus.io_addr !== io_addr_q || bus.io_we !== io_we_q ||
                            bus.io_wdata !== io_wd_q)) stab_err++;
         io_addr_q = bus.io_addr;
         io_we_q   = bus.io_we;
         io_wd_q   = bus.io_wdata;
         io_cnt++;
         if (!io_never && io_cnt == io_lat) begin
            bus.io_ack   <= 1'b1;
            bus.io_rdata <= io_val(bus.io_addr);
            if (bus.io_we) wlog.push_back({1'b1, bus.io_addr, bus.io_wdata});
            else           rlog.push_back({1'b1, bus.io_addr, 32'h0});
         end else begin
            bus.io_ack <= 1'b0;
         end
      end else begin
         io_cnt = 0;
         bus.io_ack <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the words in order, charging cycles per leg:
   // accept 1, mem read 2, IO access = latency, mem write 1, IO write after an
   // IO read 1 extra idle cycle, per-word step 1 (block only), done 1.
   task automatic model(input logic [5:0] op, input logic [15:0] s, input logic [15:0] d,
                        input logic [7:0] n, input int lat, input bit nev);
      int words;
      logic [15:0] sa, da;
      logic [31:0] v;
      bit src_io, stop;
      exp_w.delete();
      exp_r.delete();
      exp_err  = 0;
      exp_hold = 1;
      stop     = 0;
      v        = '0;
      if (op == 6'd56) begin
         exp_hold += 2;
         return;
      end
      words = (op == 6'd57) ? 1 : int'(n);
      if (words == 0) exp_hold += 1;
      for (int w = 0; w < words && !stop; w++) begin
         sa = s + 16'(4 * w);
         da = d + 16'(4 * w);
         src_io = (sa > 16'(MEM_TOP));
         if (!src_io) begin
            v = ref_mem[sa[14:2]];
            exp_r.push_back({1'b0, sa, 32'h0});
            exp_hold += 2;
         end else if (nev) begin
            exp_hold += IO_TIMEOUT; exp_err = 1; stop = 1;
         end else begin
            v = io_val(sa);
            exp_r.push_back({1'b1, sa, 32'h0});
            exp_hold += lat;
         end
         if (!stop) begin
            if (da <= 16'(MEM_TOP)) begin
               ref_mem[da[14:2]] = v;
               exp_w.push_back({1'b0, da, v});
               exp_hold += 1;
               exp_xfer++;
            end else begin
               if (src_io) exp_hold += 1;
               if (nev) begin
                  exp_hold += IO_TIMEOUT; exp_err = 1; stop = 1;
               end else begin
                  exp_w.push_back({1'b1, da, v});
                  exp_hold += lat;
                  exp_xfer++;
               end
            end
            if (op == 6'd58 && !stop) exp_hold += 1;
         end
      end
      exp_hold += 1;
   endtask

   task automatic clear_mon();
      hold_cnt = 0; done_cnt = 0; req_cnt = 0; excl_err = 0; stab_err = 0;
      wlog.delete();
      rlog.delete();
   endtask

   // Entered and left at posedge+1.
   task automatic run(input string tag, input logic [5:0] op, input logic [15:0] s,
                      input logic [15:0] d, input logic [7:0] n, input int lat, input bit nev);
      bit seen;
      model(op, s, d, n, lat, nev);
      io_lat = lat; io_never = nev;
      clear_mon();
      bus.instr_valid = 1'b1; bus.op_code = op;
      bus.src_addr = s; bus.dst_addr = d; bus.len = n;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0; bus.op_code = 6'd0;
      seen = 0;
      for (int t = 0; t < 3000 && !seen; t++) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      chk($sformatf("%s.done_seen", tag), 64'(seen), 64'd1);
      @(negedge clk);
      chk($sformatf("%s.hold_drop", tag), 64'(bus.pc_hold), 64'd0);
      chk($sformatf("%s.hold_cycles", tag), 64'(hold_cnt), 64'(exp_hold));
      chk($sformatf("%s.done_pulses", tag), 64'(done_cnt), 64'd1);
      chk($sformatf("%s.err", tag), 64'(bus.err), 64'(exp_err));
      chk($sformatf("%s.excl", tag), 64'(excl_err), 64'd0);
      chk($sformatf("%s.io_stable", tag), 64'(stab_err), 64'd0);
      chk($sformatf("%s.n_writes", tag), 64'(wlog.size()), 64'(exp_w.size()));
      for (int k = 0; k < exp_w.size() && k < wlog.size(); k++)
         chk($sformatf("%s.write%0d", tag, k), 64'(wlog[k]), 64'(exp_w[k]));
      chk($sformatf("%s.n_reads", tag), 64'(rlog.size()), 64'(exp_r.size()));
      for (int k = 0; k < exp_r.size() && k < rlog.size(); k++)
         chk($sformatf("%s.read%0d", tag, k), 64'(rlog[k]), 64'(exp_r[k]));
`ifdef MOVE_XFER_COUNT_EN
      chk($sformatf("%s.xfer", tag), 64'(bus.xfer_count), 64'(32'(exp_xfer)));
`else
      chk($sformatf("%s.xfer", tag), 64'(bus.xfer_count), 64'd0);
`endif
      @(posedge clk); #1;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk($sformatf("%s.ctl", tag),
          64'({bus.mem_rd, bus.mem_wr, bus.io_req, bus.io_we, bus.pc_hold, bus.busy, bus.done, bus.err}), 64'd0);
      chk($sformatf("%s.addr", tag), 64'({bus.mem_addr, bus.io_addr}), 64'd0);
      chk($sformatf("%s.data", tag), {bus.mem_wdata, bus.io_wdata}, 64'd0);
      chk($sformatf("%s.xfer", tag), 64'(bus.xfer_count), 64'd0);
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 4))
         0: return 16'h8000 + 16'(4 * $urandom_range(0, 255));
         1: return 16'h7FF0 + 16'(4 * $urandom_range(0, 3));
         2: return 16'hFFF8 + 16'(4 * $urandom_range(0, 1));
         default: return 16'($urandom_range(0, 8191)) << 2;
      endcase
   endfunction

   initial begin
      logic [5:0]  op;
      logic [15:0] s, d;
      logic [7:0]  n;
      bit          nev;
      int          lat;

      bus.instr_valid = 1'b0; bus.op_code = '0;
      bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
      io_lat = 1; io_never = 0; io_cnt = 0; exp_xfer = 0;
      clear_mon();
      for (int i = 0; i < 8192; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // single-word mem->mem
      run("w_mm", 6'd57, 16'h0010, 16'h0020, 8'd0, 1, 0);
      chk("w_mm.hold5", 64'(hold_cnt), 64'd5);
      chk("w_mm.mem8", 64'(mem[8]), 64'hDEAD_BEEF);

      // IO source, ack on the third request cycle
      run("w_im", 6'd57, 16'h8000, 16'h0040, 8'd0, 3, 0);
      chk("w_im.req3", 64'(req_cnt), 64'd3);
      chk("w_im.mem16", 64'(mem[16]), 64'h1234_5678);

      // mem->IO with one-cycle ack also takes 5 cycles
      run("w_mi", 6'd57, 16'h0010, 16'h8800, 8'd0, 1, 0);
      chk("w_mi.hold5", 64'(hold_cnt), 64'd5);

      // block crossing the memory/IO boundary
      run("blk3", 6'd58, 16'h7FF8, 16'h0100, 8'd3, 2, 0);
      chk("blk3.mem66", 64'(mem[66]), 64'h1234_5678);

      // IO destination that never acks
      run("tmo", 6'd57, 16'h0010, 16'h9000, 8'd0, 1, 1);
      chk("tmo.req64", 64'(req_cnt), 64'(IO_TIMEOUT));
      chk("tmo.req_low", 64'(bus.io_req), 64'd0);

      // stall and empty block
      run("stall", 6'd56, 16'h0000, 16'h0000, 8'd0, 1, 0);
      chk("stall.hold3", 64'(hold_cnt), 64'd3);
      run("len0", 6'd58, 16'h0010, 16'h0020, 8'd0, 1, 0);
      chk("len0.req", 64'(req_cnt), 64'd0);

      // unsupported op code is ignored
      bus.instr_valid = 1'b1; bus.op_code = 6'd20;
      @(negedge clk);
      chk("ign.hold", 64'(bus.pc_hold), 64'd0);
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      chk("ign.busy", 64'(bus.busy), 64'd0);

      // reset in the middle of an IO source leg
      clear_mon();
      io_never = 1;
      bus.instr_valid = 1'b1; bus.op_code = 6'd58;
      bus.src_addr = 16'h8000; bus.dst_addr = 16'h0100; bus.len = 8'd4;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mid.pre_req", 64'(bus.io_req), 64'd1);
      rst = 1'b1;
      #1;
      chk_outputs_zero("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid.no_done", 64'(done_cnt), 64'd0);
      exp_xfer = 0;
      @(posedge clk); #1;
      run("after_rst", 6'd57, 16'h0020, 16'h0030, 8'd0, 1, 0);

      // randomized instructions against the reference model
      for (int i = 0; i < 40; i++) begin
         op  = ($urandom_range(0, 9) < 4) ? 6'd57 : 6'd58;
         n   = 8'($urandom_range(0, 5));
         s   = pick_addr();
         d   = pick_addr();
         lat = $urandom_range(1, 4);
         nev = ($urandom_range(0, 15) == 0);
         run($sformatf("rnd%0d", i), op, s, d, n, lat, nev);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Executes the multi-cycle MOVE instructions (op_code 56/57/58) between data memory and the IO space.
- Asserts pc_hold to the program counter for the full duration of each MOVE.
- Acts as the responder to the PC's MOVE stall protocol: the PC holds pcout4 while pc_hold=1 and advances by 4 on the first cycle pc_hold=0.
- Sits beside the data memory and the IO bus, in front of both.

Parameters:
- MEM_TOP, 32764: highest memory byte address (8191*4). addr <= MEM_TOP is memory; addr > MEM_TOP is IO.
- IO_TIMEOUT, 64: maximum cycles to wait for io_ack before aborting.
- LEN_W, 8: width of the block-move length field.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  op_code/operands are valid this cycle
- op_code  in  6  56=STALL1, 57=MOVE word, 58=MOVE block; any other value is ignored
- src_addr  in  16  source byte address
- dst_addr  in  16  destination byte address
- len  in  LEN_W  word count (op 58 only)
- mem_addr  out  14  word address (addr[15:2])
- mem_rd  out  1  memory read strobe; data returned 1 cycle later
- mem_wr  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- io_req  out  1  IO request; held high until io_ack
- io_we  out  1  1=IO write, 0=IO read
- io_addr  out  16  IO byte address
- io_wdata  out  32  IO write data
- io_rdata  in  32  IO read data, valid with io_ack
- io_ack  in  1  IO completion
- pc_hold  out  1  stall the PC
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at completion
- err  out  1  IO timeout flag; sticky until next accept
- xfer_count  out  32  transferred-word count (see Optional Feature)

Behaviour:
- Reset (async): state=IDLE; all outputs 0; internal data, address, remaining-count and timeout registers cleared. rst mid-operation aborts immediately; no done pulse is generated.
- Accept: in IDLE, when instr_valid=1 and op_code is 56, 57 or 58:
  - latch src, dst and len;
  - clear err;
  - pc_hold=1 combinationally in the accept cycle.
- In any other state, instr_valid is ignored.
- pc_hold = accept | (state != IDLE). It drops in the cycle after DONE.
- States:
  - IDLE
  - STALL
  - SRC_MEM (mem_rd=1)
  - SRC_CAP (data <= mem_rdata)
  - SRC_IO (io_req=1, io_we=0; on io_ack, data <= io_rdata)
  - DST_MEM (mem_wr=1, mem_wdata=data)
  - DST_IO (io_req=1, io_we=1, io_wdata=data; wait for io_ack)
  - NEXT
  - DONE (done=1)
- op 56: IDLE -> STALL -> DONE -> IDLE.
- op 57 source leg: IDLE -> SRC_MEM -> SRC_CAP if src <= MEM_TOP, else IDLE -> SRC_IO.
- op 57 destination leg: then DST_MEM if dst <= MEM_TOP, else DST_IO; then DONE.
  - mem->mem and mem->IO (ack in 1 cycle): pc_hold is high for 5 cycles including the accept cycle.
- op 58 (block move): each word uses the op 57 legs, then NEXT:
  - src += 4, dst += 4, both mod 2^16 (wrap-around allowed);
  - remaining -= 1;
  - remaining != 0 -> next source leg; remaining == 0 -> DONE.
  - The MEM_TOP region is re-evaluated per word, so a block may cross the memory/IO boundary.
  - len == 0: IDLE -> NEXT -> DONE, with no transfer.
- IO handshake:
  - io_req/io_addr/io_we/io_wdata stay stable until io_ack is sampled high.
  - io_req drops in the cycle after ack.
  - io_ack while io_req=0 is ignored.
- Timeout: a counter runs in SRC_IO/DST_IO. After IO_TIMEOUT cycles without ack: err=1, io_req=0, go to DONE; remaining words are abandoned.
- mem_rd and mem_wr are never asserted in the same cycle. io_req and a mem strobe are never asserted in the same cycle.

Optional Feature:
- Macro MOVE_XFER_COUNT_EN.
- When defined: xfer_count increments by 1 on each completed word write (DST_MEM, or DST_IO with ack). It is cumulative, cleared only by rst, and wraps at 2^32.
- When undefined: xfer_count is tied to 0 and no counter is synthesized.

Test Plan:
- op 57, src=0x0010, dst=0x0020, mem[4]=0xDEADBEEF -> mem_rd at word 4, mem_wr at word 8 with 0xDEADBEEF; pc_hold high 5 cycles; done pulses once.
- op 57, src=0x8000 (IO), dst=0x0040, io_ack after 3 cycles with io_rdata=0x12345678 -> io_req high exactly 3 cycles with io_we=0; mem_wr word 16 = 0x12345678.
- op 58, src=0x7FF8, dst=0x0100, len=3 -> reads 0x7FF8 and 0x7FFC from memory, 0x8000 via IO; writes words 64,65,66; done after the third word; xfer_count=3 if MOVE_XFER_COUNT_EN.
- op 57, dst=0x9000, io_ack never asserted -> after IO_TIMEOUT=64 cycles: err=1, io_req=0, done pulse, pc_hold drops the next cycle.
- op 56 -> pc_hold high for 3 cycles (accept, STALL, DONE); no mem or IO strobes. op 58 with len=0 -> done with zero strobes.
- rst asserted during SRC_IO of op 58 -> all outputs 0 immediately; no done pulse; the next accept works normally.
